// File: rtl/adc_spi_capture.sv
// Multi-lane SPI ADC acquisition engine: drives CNV_n/SCK, deserialises SDO lanes
// into parallel sample words with per-lane ready strobes, burst/continuous modes.
module adc_spi_capture #(
    parameter int N_LANES     = 8,
    parameter int N_SCK       = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int SCK_DIV     = 2,
    parameter int CONV_CYCLES = 4,
    parameter int WAIT_CYCLES = 60,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_mode,
    input  logic [CNT_W-1:0]               i_samples_count,
    input  logic [N_LANES-1:0]             i_lane_en,
    output logic                           o_busy,
    output logic                           o_finished,
    output logic [CNT_W-1:0]               o_sample_cnt,
    output logic [N_SCK-1:0]               o_ADC_CNV_n,
    output logic [N_SCK-1:0]               o_ADC_SCK,
    input  logic [N_LANES-1:0]             i_ADC_SDO,
    output logic [N_LANES*SAMPLE_BITS-1:0] o_data,
    output logic [N_LANES-1:0]             o_rdy
);

    localparam int M_A    = (CONV_CYCLES > WAIT_CYCLES) ? CONV_CYCLES : WAIT_CYCLES;
    localparam int M_B    = (GAP_CYCLES > 2 * SCK_DIV) ? GAP_CYCLES : 2 * SCK_DIV;
    localparam int PH_MAX = (M_A > M_B) ? M_A : M_B;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BIT_W  = $clog2(SAMPLE_BITS + 1);
    localparam int DW     = N_LANES * SAMPLE_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DW-1:0]       shift_q, shift_d;
    logic [DW-1:0]       data_q, data_d;
    logic [N_LANES-1:0]  rdy_q, rdy_d;
    logic [N_LANES-1:0]  en_q, en_d;
    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mode_q, mode_d;
    logic                stop_q, stop_d;
    logic                fin_q, fin_d;
    logic                busy_q, busy_d;
    logic [N_SCK-1:0]    cnv_n_q, cnv_n_d;
    logic [N_SCK-1:0]    sck_q, sck_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = '0;
        en_d    = en_q;
        scnt_d  = scnt_q;
        count_d = count_q;
        mode_d  = mode_q;
        fin_d   = 1'b0;
        stop_d  = stop_q;

        if (state_q != IDLE && i_stop) begin
            stop_d = 1'b1;
        end else begin
            stop_d = stop_q;
        end

        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (i_start) begin
                    mode_d  = i_mode;
                    count_d = i_samples_count;
                    en_d    = i_lane_en;
                    scnt_d  = '0;
                    if (i_mode && (i_samples_count == '0)) begin
                        fin_d = 1'b1;
                    end else begin
                        state_d = CONV;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (cnt_q == PH_W'(CONV_CYCLES - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q == PH_W'(WAIT_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            SHIFT: begin
                // SDO is captured on the last clk of each SCK-high phase
                if (cnt_q == PH_W'(SCK_DIV - 1)) begin
                    for (int k = 0; k < N_LANES; k++) begin
                        shift_d[k*SAMPLE_BITS +: SAMPLE_BITS] =
                            (shift_q[k*SAMPLE_BITS +: SAMPLE_BITS] << 1)
                            | SAMPLE_BITS'(i_ADC_SDO[k]);
                    end
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == PH_W'(2 * SCK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(SAMPLE_BITS - 1)) begin
                        state_d = GAP;
                        rdy_d   = en_q;
                        scnt_d  = scnt_q + CNT_W'(1);
                        for (int k = 0; k < N_LANES; k++) begin
                            data_d[k*SAMPLE_BITS +: SAMPLE_BITS] = en_q[k]
                                ? shift_q[k*SAMPLE_BITS +: SAMPLE_BITS]
                                : {SAMPLE_BITS{1'b0}};
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == PH_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if ((mode_q && (scnt_q == count_q)) || stop_q || i_stop) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = CONV;
                    end
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
        if (state_d == CONV) begin
            cnv_n_d = '0;
        end else begin
            cnv_n_d = '1;
        end
        if (state_d == SHIFT && cnt_d < PH_W'(SCK_DIV)) begin
            sck_d = '1;
        end else begin
            sck_d = '0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= '0;
            en_q    <= '0;
            scnt_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            stop_q  <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnv_n_q <= '1;
            sck_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            en_q    <= en_d;
            scnt_q  <= scnt_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            stop_q  <= stop_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
            cnv_n_q <= cnv_n_d;
            sck_q   <= sck_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_finished   = fin_q;
    assign o_sample_cnt = scnt_q;
    assign o_ADC_CNV_n  = cnv_n_q;
    assign o_ADC_SCK    = sck_q;
    assign o_data       = data_q;
    assign o_rdy        = rdy_q;

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
Parametrised acquisition engine for the multi-lane SPI ADC front end. It generates the conversion strobe and gated serial clocks, and deserialises N_LANES SDO lanes into parallel words. Each completed sample set is presented with per-lane ready strobes to the capture/ILA path. It sits between the differential I/O buffers and the data sink. It adds burst/continuous modes, sample counting, lane masking and clean stop, which the fixed-width predecessor lacks.

Parameters:
N_LANES, 8, number of SDO input lanes.
N_SCK, 4, number of SCK/CNV output groups; N_LANES must be a multiple of N_SCK.
SAMPLE_BITS, 16, bits shifted per lane per sample, MSB first.
SCK_DIV, 2, clk cycles per SCK half-period (>=1).
CONV_CYCLES, 4, CNV_n active-low pulse width in clk cycles (>=1).
WAIT_CYCLES, 60, clk cycles from CNV_n release to first SCK edge (>=1).
GAP_CYCLES, 4, clk cycles after the last SCK bit before the next CNV_n (>=1).
CNT_W, 16, width of the sample counter.

Ports:
clk  in  1  single system clock.
rst  in  1  synchronous, active-high reset.
i_start  in  1  level; a high level sampled in IDLE starts acquisition.
i_stop  in  1  pulse; requests a stop at the next sample boundary.
i_mode  in  1  0 = continuous, 1 = burst of i_samples_count samples.
i_samples_count  in  CNT_W  burst length, latched at start.
i_lane_en  in  N_LANES  lane mask, latched at start.
o_busy  out  1  high in any state other than IDLE.
o_finished  out  1  one-cycle pulse when acquisition ends.
o_sample_cnt  out  CNT_W  number of samples completed since the last start.
o_ADC_CNV_n  out  N_SCK  conversion strobe, active low, all groups identical.
o_ADC_SCK  out  N_SCK  serial clock, idle low, all groups identical.
i_ADC_SDO  in  N_LANES  serial data lanes; lane k belongs to SCK group k/(N_LANES/N_SCK).
o_data  out  N_LANES*SAMPLE_BITS  lane k occupies bits [k*SAMPLE_BITS +: SAMPLE_BITS].
o_rdy  out  N_LANES  one-cycle strobe per enabled lane when o_data updates.

Behaviour:
- Reset, synchronous: state = IDLE. o_ADC_CNV_n = all 1, o_ADC_SCK = 0, o_data = 0, o_rdy = 0, o_busy = 0, o_finished = 0, o_sample_cnt = 0, and all internal counters = 0. A reset asserted mid-sample aborts the sample immediately. No o_rdy or o_finished is emitted.
- Single phase counter. States are IDLE, CONV, WAIT, SHIFT, GAP.
- IDLE: if i_start = 1, latch i_mode, i_samples_count and i_lane_en, and clear o_sample_cnt.
  - If burst mode and count = 0: pulse o_finished the next cycle and stay in IDLE.
  - Otherwise go to CONV.
- CONV: CNV_n = 0 for CONV_CYCLES cycles, then go to WAIT.
- WAIT: CNV_n = 1 for WAIT_CYCLES cycles, then go to SHIFT.
- SHIFT: SAMPLE_BITS bit periods. Each period is SCK high for SCK_DIV cycles, then low for SCK_DIV cycles.
  - SDO is sampled in the last clk cycle of each SCK-high phase and shifted left into a per-lane shift register.
  - After the final low phase, go to GAP.
- GAP entry cycle (registered):
  - o_data <= the shift registers. Disabled lanes are written as 0.
  - o_rdy <= i_lane_en latched, for exactly 1 cycle.
  - o_sample_cnt increments, wrapping at 2^CNT_W.
- GAP: lasts GAP_CYCLES. At its end:
  - If burst mode and o_sample_cnt == count, or a stop is pending: go to IDLE and pulse o_finished for 1 cycle.
  - Otherwise go to CONV.
- i_stop during any non-IDLE state sets a pending flag. The current sample always completes; there are no partial words.
  - The pending flag clears on entering IDLE.
  - i_stop in IDLE is ignored.
- i_start held high in IDLE after a finish restarts acquisition on the next cycle. i_start is ignored outside IDLE.
- Sample period = CONV_CYCLES + WAIT_CYCLES + 2·SCK_DIV·SAMPLE_BITS + GAP_CYCLES. With defaults this is 132 cycles.
- Latency with i_start sampled at cycle 0:
  - CNV_n is low for cycles 1–4.
  - The first SCK rise is at cycle 65.
  - o_rdy is asserted at cycle 129.
  - The next CNV_n falls at cycle 133.

Test Plan:
1. Reset then idle → CNV_n = 1111, SCK = 0, o_data = 0, o_rdy = 0, o_busy = 0 for 200 cycles.
2. Burst, count = 1, all lanes enabled. Lane k drives the pattern 16'hA5A0+k, MSB first, timed to SCK → one o_rdy = 8'hFF at cycle 129. o_data lane k = A5A0+k. o_finished pulses at cycle 133. o_sample_cnt = 1.
3. Burst, count = 3, i_lane_en = 8'h0F → three o_rdy = 8'h0F strobes at cycles 129, 261 and 393. Upper lanes of o_data = 0. o_finished pulses once.
4. Continuous mode, i_stop pulsed at cycle 200 → the sample in flight completes with o_rdy at cycle 261. Then o_finished pulses. No further CNV_n.
5. Burst, count = 0 → o_finished pulses one cycle after start. CNV_n never asserts.
6. rst asserted at cycle 100 mid-SHIFT → all outputs return to reset values the next cycle. No o_rdy or o_finished follows.
